// File: rtl/fp_pkg.sv
// Shared defaults, FSM encoding and packed-float layout for the FP normalizer.
// The EXP_MAX and fp_t definitions assume the default single-precision widths.
package fp_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int FRAC_W_DEF = 23;

  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [FRAC_W_DEF-1:0] frac;
  } fp_t;

endpackage

// File: rtl/fp_round_pack.sv
// One normalization step: classify the working value, round a right shift, pack.
// Pure combinational; FP_NORM_ROUND_EN selects round-to-nearest-even over truncation.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    sign,
  input  logic [EXP_W-1:0]        exp,
  input  logic [FRAC_W+1:0]       sum,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    zero,
  output logic                    shift_left
);

  localparam logic [EXP_W:0] EXP_ALL = {1'b0, {EXP_W{1'b1}}};

  logic              inc;
  logic              rnd_carry;
  logic [FRAC_W-1:0] frac_rnd;
  logic [EXP_W:0]    exp_up;

  // Only one bit is dropped, so guard is sum[0] and the new lsb is sum[1].
`ifdef FP_NORM_ROUND_EN
  assign inc = sum[0] & sum[1];
`else
  assign inc = 1'b0;
`endif

  // Hidden bit is implied by sum[MSB]; a carry out of the fraction means 1.0 at exp+2.
  assign {rnd_carry, frac_rnd} = {1'b0, sum[FRAC_W:1]} + {{FRAC_W{1'b0}}, inc};
  assign exp_up = {1'b0, exp} + (EXP_W+1)'(1) + (EXP_W+1)'(rnd_carry);

  always_comb begin
    result     = '0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    zero       = 1'b0;
    shift_left = 1'b0;
    if (sum == '0) begin
      zero = 1'b1;
    end else if (exp == '1) begin
      result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      overflow = 1'b1;
    end else if (sum[FRAC_W+1]) begin
      if (exp_up >= EXP_ALL) begin
        result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        overflow = 1'b1;
      end else begin
        result = {sign, exp_up[EXP_W-1:0], frac_rnd};
      end
    end else if (sum[FRAC_W]) begin
      result = {sign, exp, sum[FRAC_W-1:0]};
    end else if (exp <= EXP_W'(1)) begin
      result    = {sign, {EXP_W{1'b0}}, sum[FRAC_W-1:0]};
      underflow = 1'b1;
    end else begin
      shift_left = 1'b1;
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Normalizes a raw adder sum into an IEEE-754 word; out_valid 2 cycles after accept plus one per left shift.
// Single operand in flight: in_ready low until the result handshakes; rounding via FP_NORM_ROUND_EN.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [FRAC_W+1:0]     in_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out_result,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  out_zero
);

  state_t                state, state_nxt;
  logic                  ready_ok;
  logic                  sign_q;
  logic [EXP_W-1:0]      exp_q;
  logic [FRAC_W+1:0]     sum_q;
  logic [EXP_W+FRAC_W:0] rp_result;
  logic                  rp_ovf, rp_unf, rp_zero, rp_shift;
  logic                  accept;

  fp_round_pack #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round_pack (
    .sign       (sign_q),
    .exp        (exp_q),
    .sum        (sum_q),
    .result     (rp_result),
    .overflow   (rp_ovf),
    .underflow  (rp_unf),
    .zero       (rp_zero),
    .shift_left (rp_shift)
  );

  assign accept = (state == S_IDLE) && ready_ok && in_valid;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ready_ok;
        if (accept) state_nxt = S_NORM;
      end
      S_NORM:  if (!rp_shift) state_nxt = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ready_ok      <= 1'b0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      sum_q         <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_zero      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_ok <= 1'b1;
      if (accept) begin
        sign_q <= in_sign;
        // A zero exponent denotes a denormal operand, which scales like exp=1.
        exp_q  <= (in_exp == '0) ? EXP_W'(1) : in_exp;
        sum_q  <= in_sum;
      end
      if (state == S_NORM) begin
        if (rp_shift) begin
          sum_q <= sum_q << 1;
          exp_q <= exp_q - EXP_W'(1);
        end else begin
          out_result    <= rp_result;
          out_overflow  <= rp_ovf;
          out_underflow <= rp_unf;
          out_zero      <= rp_zero;
        end
      end
      // The result registers settle on DONE entry; valid follows one cycle later.
      out_valid <= (state == S_DONE) && !(out_valid && out_ready);
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Table-driven and randomized checks of fp_normalizer against a closed-form reference model.
module tb_fp_normalizer;
  import fp_pkg::*;

`ifdef FP_NORM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] sum;
    logic [31:0] res;
    logic [2:0]  fl;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  fp_normalizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_sum        (in_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_zero      (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Value-level model: find the leading one, compute the total shift in one go.
  function automatic void model(input logic s, input logic [7:0] ei, input logic [24:0] sm,
                                output logic [31:0] r, output logic [2:0] fl, output int lat);
    int     e, p, k;
    longint q, m;
    fp_t    f;
    e   = (ei == 8'h00) ? 1 : int'(ei);
    lat = 2;
    fl  = 3'b000;
    f   = '0;
    if (sm == 25'h0) begin
      fl = 3'b001;
    end else if (ei == EXP_MAX) begin
      f  = '{s, EXP_MAX, 23'h0};
      fl = 3'b100;
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if (sm[i]) p = i;
      if (p == 24) begin
        q = longint'(sm) / 2;
        if (ROUND && (sm % 2 == 1) && (q % 2 == 1)) q = q + 1;
        e = e + 1;
        if (q == (64'd1 << 24)) begin
          q = 64'd1 << 23;
          e = e + 1;
        end
        if (e >= 255) begin
          f  = '{s, EXP_MAX, 23'h0};
          fl = 3'b100;
        end else begin
          f = '{s, 8'(e), 23'(q)};
        end
      end else begin
        k = 23 - p;
        if (k > e - 1) k = e - 1;
        m   = longint'(sm) << k;
        lat = 2 + k;
        e   = e - k;
        if (m >= (64'd1 << 23)) begin
          f = '{s, 8'(e), 23'(m)};
        end else begin
          f  = '{s, 8'h00, 23'(m)};
          fl = 3'b010;
        end
      end
    end
    r = f;
  endfunction

  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] sm,
                       input logic [31:0] xr, input logic [2:0] xf, input int xl, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_sum   = sm;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(xl));
    chk("result", out_result, xr);
    chk("flags", {29'h0, out_overflow, out_underflow, out_zero}, {29'h0, xf});
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, xr);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] xr;
    logic [2:0]  xf;
    int          xl;
    logic        s;
    logic [7:0]  e;
    logic [24:0] sm;
    int          sel, pos, seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sum    = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {29'h0, out_overflow, out_underflow, out_zero}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    tbl.push_back('{1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 3'b000, 2, 0});
    tbl.push_back('{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 2, 0});
    tbl.push_back('{1'b1, 8'h7F, 25'h0200000, 32'hBE800000, 3'b000, 4, 3});
    tbl.push_back('{1'b0, 8'h7F, 25'h1FFFFFF, ROUND ? 32'h40800000 : 32'h407FFFFF, 3'b000, 2, 0});
    tbl.push_back('{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b100, 2, 0});
    tbl.push_back('{1'b1, 8'h55, 25'h0000000, 32'h00000000, 3'b001, 2, 0});
    tbl.push_back('{1'b1, 8'hFF, 25'h0C00000, 32'hFF800000, 3'b100, 2, 0});
    tbl.push_back('{1'b0, 8'h03, 25'h0000100, 32'h00000400, 3'b010, 4, 0});
    tbl.push_back('{1'b0, 8'h00, 25'h0800000, 32'h00800000, 3'b000, 2, 0});
    tbl.push_back('{1'b0, 8'h00, 25'h0000001, 32'h00000001, 3'b010, 2, 0});
    tbl.push_back('{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 3'b000, 25, 0});
    tbl.push_back('{1'b0, 8'hFD, 25'h1FFFFFF, ROUND ? 32'h7F800000 : 32'h7F7FFFFF,
                    ROUND ? 3'b100 : 3'b000, 2, 0});
    tbl.push_back('{1'b0, 8'h7F, 25'h1000001, 32'h40000000, 3'b000, 2, 0});
    tbl.push_back('{1'b0, 8'h7F, 25'h1000003, ROUND ? 32'h40000002 : 32'h40000001, 3'b000, 2, 1});

    foreach (tbl[i])
      do_op(tbl[i].sign, tbl[i].exp, tbl[i].sum, tbl[i].res, tbl[i].fl, tbl[i].lat, tbl[i].hold);

    // Reset in the middle of a long left-shift sequence must drop the operation.
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h7F;
    in_sum   = 25'h0000001;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      step();
    end
    chk("no_valid_after_mid_reset", 32'(seen), 32'd0);

    for (int t = 0; t < 200; t++) begin
      s   = 1'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       e = 8'h00;
        1:       e = 8'h01;
        2:       e = 8'hFE;
        3:       e = 8'hFF;
        4:       e = 8'hFD;
        default: e = 8'($urandom_range(0, 255));
      endcase
      pos = $urandom_range(0, 25);
      if (pos == 25) sm = 25'h0;
      else           sm = (25'h1 << pos) | (25'($urandom) & ((25'h1 << pos) - 25'h1));
      model(s, e, sm, xr, xf, xl);
      do_op(s, e, sm, xr, xf, xl, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
